// File: rtl/mbist_mem_responder.sv
// ============================================================================
// Module   : mbist_mem_responder
// Brief    : MBIST memory-side responder with programmable SA/TF/CF fault table
// Revision : 1.0
// ============================================================================
`default_nettype none

module mbist_mem_responder #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 256,
  parameter int NUM_FAULTS = 4,
  parameter int FIDX_W     = 2,
  parameter int BIT_W      = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_en,
  input  logic                  write_read,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rdata_valid,
  output logic                  addr_oor,
  input  logic                  fault_wr_en,
  input  logic [FIDX_W-1:0]     fault_idx,
  input  logic [2:0]            fault_type,
  input  logic [ADDR_WIDTH-1:0] fault_addr,
  input  logic [BIT_W-1:0]      fault_bit,
  input  logic [ADDR_WIDTH-1:0] fault_agg_addr,
  input  logic                  fault_clear,
  output logic [15:0]           wr_count,
  output logic [15:0]           rd_count
);

  localparam int                c_IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] c_DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [2:0]        c_FT_SA0    = 3'd1;
  localparam logic [2:0]        c_FT_SA1    = 3'd2;
  localparam logic [2:0]        c_FT_TF_UP  = 3'd3;
  localparam logic [2:0]        c_FT_TF_DN  = 3'd4;
  localparam logic [2:0]        c_FT_CF_INV = 3'd5;
  localparam logic [15:0]       c_CNT_MAX   = 16'hFFFF;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic [2:0]            r_ftype [NUM_FAULTS];
  logic [ADDR_WIDTH-1:0] r_faddr [NUM_FAULTS];
  logic [BIT_W-1:0]      r_fbit  [NUM_FAULTS];
  logic [ADDR_WIDTH-1:0] r_fagg  [NUM_FAULTS];

  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_rdata_valid;
  logic                  r_addr_oor;
  logic [15:0]           r_wr_count;
  logic [15:0]           r_rd_count;

  logic                  w_in_range;
  logic [c_IDX_W-1:0]    w_idx;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic [DATA_WIDTH-1:0] w_old;
  logic [DATA_WIDTH-1:0] w_new;
  logic [DATA_WIDTH-1:0] w_view;
  logic [NUM_FAULTS-1:0] w_hit;
  logic [NUM_FAULTS-1:0] w_cf_fire;
  logic [DATA_WIDTH-1:0] w_vic_mask [NUM_FAULTS];

  assign w_in_range = ({1'b0, address} < c_DEPTH_EXT);
  assign w_idx      = address[c_IDX_W-1:0];
  assign w_wr_acc   = mem_en & write_read & w_in_range;
  assign w_rd_acc   = mem_en & ~write_read & w_in_range;
  assign w_old      = r_mem[w_idx];

  always_comb begin
    for (int i = 0; i < NUM_FAULTS; i++) begin
      w_hit[i] = (r_faddr[i] == address);
    end
  end

  // Transition faults compare against the pre-write word; stuck-ats then override.
  always_comb begin
    w_new = wdata;
    for (int i = 0; i < NUM_FAULTS; i++) begin
      if (w_hit[i] && r_ftype[i] == c_FT_TF_UP && !w_old[r_fbit[i]] && wdata[r_fbit[i]])
        w_new[r_fbit[i]] = 1'b0;
      if (w_hit[i] && r_ftype[i] == c_FT_TF_DN && w_old[r_fbit[i]] && !wdata[r_fbit[i]])
        w_new[r_fbit[i]] = 1'b1;
    end
    for (int i = 0; i < NUM_FAULTS; i++) begin
      if (w_hit[i] && r_ftype[i] == c_FT_SA0) w_new[r_fbit[i]] = 1'b0;
      if (w_hit[i] && r_ftype[i] == c_FT_SA1) w_new[r_fbit[i]] = 1'b1;
    end
  end

  always_comb begin
    w_view = w_old;
    for (int i = 0; i < NUM_FAULTS; i++) begin
      if (w_hit[i] && r_ftype[i] == c_FT_SA0) w_view[r_fbit[i]] = 1'b0;
      if (w_hit[i] && r_ftype[i] == c_FT_SA1) w_view[r_fbit[i]] = 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_FAULTS; i++) begin
      w_cf_fire[i] = w_wr_acc && (r_ftype[i] == c_FT_CF_INV) &&
                     (r_faddr[i] != r_fagg[i]) &&
                     ({1'b0, r_faddr[i]} < c_DEPTH_EXT) &&
                     ({1'b0, r_fagg[i]} < c_DEPTH_EXT) &&
                     (address == r_fagg[i]) &&
                     (w_new[r_fbit[i]] != w_old[r_fbit[i]]);
    end
  end

  // Entries sharing a victim word merge their flips so each writer stores the same value.
  always_comb begin
    for (int i = 0; i < NUM_FAULTS; i++) begin
      w_vic_mask[i] = '0;
      for (int j = 0; j < NUM_FAULTS; j++) begin
        if (w_cf_fire[j] && r_faddr[j] == r_faddr[i])
          w_vic_mask[i][r_fbit[j]] = ~w_vic_mask[i][r_fbit[j]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (w_wr_acc) r_mem[w_idx] <= w_new;
      for (int i = 0; i < NUM_FAULTS; i++) begin
        if (|w_vic_mask[i])
          r_mem[r_faddr[i][c_IDX_W-1:0]] <= r_mem[r_faddr[i][c_IDX_W-1:0]] ^ w_vic_mask[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || fault_clear) begin
      for (int i = 0; i < NUM_FAULTS; i++) r_ftype[i] <= 3'd0;
    end else if (fault_wr_en) begin
      r_ftype[fault_idx] <= fault_type;
    end
    if (fault_wr_en) begin
      r_faddr[fault_idx] <= fault_addr;
      r_fbit[fault_idx]  <= fault_bit;
      r_fagg[fault_idx]  <= fault_agg_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rdata       <= '0;
      r_rdata_valid <= 1'b0;
      r_addr_oor    <= 1'b0;
      r_wr_count    <= '0;
      r_rd_count    <= '0;
    end else begin
      r_rdata_valid <= mem_en & ~write_read;
      r_addr_oor    <= mem_en & ~w_in_range;
      if (mem_en && !write_read) r_rdata <= w_in_range ? w_view : '0;
      if (w_wr_acc && r_wr_count != c_CNT_MAX) r_wr_count <= r_wr_count + 16'd1;
      if (w_rd_acc && r_rd_count != c_CNT_MAX) r_rd_count <= r_rd_count + 16'd1;
    end
  end

  assign rdata       = r_rdata;
  assign rdata_valid = r_rdata_valid;
  assign addr_oor    = r_addr_oor;
  assign wr_count    = r_wr_count;
  assign rd_count    = r_rd_count;

endmodule

`default_nettype wire

// File: tb/tb_mbist_mem_responder.sv
// ============================================================================
// Module   : tb_mbist_mem_responder
// Brief    : Directed vector table, corner sequences and random run vs. a model
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mbist_mem_responder;

  localparam int K_WR = 0, K_RD = 1, K_FSET = 2, K_FCLR = 3, K_IDLE = 4;
  localparam logic [63:0] c_A5   = 64'hA5A5_A5A5_A5A5_A5A5;
  localparam logic [63:0] c_ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_en = 1'b0, write_read = 1'b0;
  logic [15:0] address = '0;
  logic [63:0] wdata = '0;
  logic [63:0] rdata;
  logic        rdata_valid, addr_oor;
  logic        fault_wr_en = 1'b0, fault_clear = 1'b0;
  logic [1:0]  fault_idx = '0;
  logic [2:0]  fault_type = '0;
  logic [15:0] fault_addr = '0, fault_agg_addr = '0;
  logic [5:0]  fault_bit = '0;
  logic [15:0] wr_count, rd_count;

  int n_tests = 0;
  int n_fail  = 0;

  mbist_mem_responder dut (
    .clk(clk), .rst_n(rst_n), .mem_en(mem_en), .write_read(write_read),
    .address(address), .wdata(wdata), .rdata(rdata), .rdata_valid(rdata_valid),
    .addr_oor(addr_oor), .fault_wr_en(fault_wr_en), .fault_idx(fault_idx),
    .fault_type(fault_type), .fault_addr(fault_addr), .fault_bit(fault_bit),
    .fault_agg_addr(fault_agg_addr), .fault_clear(fault_clear),
    .wr_count(wr_count), .rd_count(rd_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [15:0] addr;
    logic [63:0] data;
    logic [1:0]  fidx;
    logic [2:0]  ftype;
    logic [5:0]  fbit;
    logic [15:0] fagg;
    bit          ev;
    bit          eo;
    logic [63:0] er;
    int          ew;
    int          erd;
  } vec_t;

  // Reference model state: plain word array plus a list of fault records.
  logic [63:0] m_mem [256];
  int          m_ft [4];
  logic [15:0] m_fa [4];
  logic [15:0] m_fg [4];
  int          m_fb [4];
  int          m_wr, m_rd;
  bit          m_valid, m_oor;
  logic [63:0] m_rdata;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input bit en, input bit wr, input logic [15:0] a, input logic [63:0] d,
                       input bit fwe, input logic [1:0] fi, input logic [2:0] ft,
                       input logic [15:0] fa, input logic [5:0] fb, input logic [15:0] fg,
                       input bit fclr);
    mem_en = en; write_read = wr; address = a; wdata = d;
    fault_wr_en = fwe; fault_idx = fi; fault_type = ft; fault_addr = fa;
    fault_bit = fb; fault_agg_addr = fg; fault_clear = fclr;
    @(posedge clk);
    #1;
    mem_en = 1'b0; fault_wr_en = 1'b0; fault_clear = 1'b0;
  endtask

  function automatic logic [63:0] model_view(input logic [15:0] a);
    logic [63:0] v;
    v = m_mem[a[7:0]];
    for (int i = 0; i < 4; i++) begin
      if (m_fa[i] == a && m_ft[i] == 1) v[m_fb[i]] = 1'b0;
      if (m_fa[i] == a && m_ft[i] == 2) v[m_fb[i]] = 1'b1;
    end
    return v;
  endfunction

  task automatic model_access(input bit en, input bit wr, input logic [15:0] a, input logic [63:0] d);
    bit inr;
    logic [63:0] old, nw;
    inr = (a < 16'd256);
    m_valid = en && !wr;
    m_oor   = en && !inr;
    if (en && !wr) begin
      m_rdata = inr ? model_view(a) : 64'd0;
      if (inr && m_rd < 65535) m_rd++;
    end
    if (en && wr && inr) begin
      old = m_mem[a[7:0]];
      nw  = d;
      for (int i = 0; i < 4; i++) begin
        if (m_fa[i] == a && m_ft[i] == 3 && old[m_fb[i]] == 1'b0 && d[m_fb[i]] == 1'b1) nw[m_fb[i]] = 1'b0;
        if (m_fa[i] == a && m_ft[i] == 4 && old[m_fb[i]] == 1'b1 && d[m_fb[i]] == 1'b0) nw[m_fb[i]] = 1'b1;
      end
      for (int i = 0; i < 4; i++) begin
        if (m_fa[i] == a && m_ft[i] == 1) nw[m_fb[i]] = 1'b0;
        if (m_fa[i] == a && m_ft[i] == 2) nw[m_fb[i]] = 1'b1;
      end
      m_mem[a[7:0]] = nw;
      for (int i = 0; i < 4; i++) begin
        if (m_ft[i] == 5 && m_fg[i] == a && m_fa[i] != m_fg[i] && m_fa[i] < 256 &&
            old[m_fb[i]] != nw[m_fb[i]])
          m_mem[m_fa[i][7:0]][m_fb[i]] = ~m_mem[m_fa[i][7:0]][m_fb[i]];
      end
      if (m_wr < 65535) m_wr++;
    end
  endtask

  task automatic run_cycle(input bit en, input bit wr, input logic [15:0] a, input logic [63:0] d,
                           input bit fwe, input logic [1:0] fi, input logic [2:0] ft,
                           input logic [15:0] fa, input logic [5:0] fb, input logic [15:0] fg,
                           input bit fclr);
    model_access(en, wr, a, d);
    if (fclr) begin
      for (int i = 0; i < 4; i++) m_ft[i] = 0;
    end else if (fwe) begin
      m_ft[fi] = (ft > 3'd5) ? 0 : int'(ft);
      m_fa[fi] = fa; m_fb[fi] = int'(fb); m_fg[fi] = fg;
    end
    drive(en, wr, a, d, fwe, fi, ft, fa, fb, fg, fclr);
    chk("rnd_valid", 64'(rdata_valid), 64'(m_valid));
    chk("rnd_oor", 64'(addr_oor), 64'(m_oor));
    chk("rnd_rdata", rdata, m_rdata);
    chk("rnd_wr_count", 64'(wr_count), 64'(m_wr));
    chk("rnd_rd_count", 64'(rd_count), 64'(m_rd));
  endtask

  function automatic vec_t mk(int k, logic [15:0] a, logic [63:0] d, logic [1:0] fi,
                              logic [2:0] ft, logic [5:0] fb, logic [15:0] fg,
                              bit ev, bit eo, logic [63:0] er, int ew, int erd);
    vec_t v;
    v.kind = k; v.addr = a; v.data = d; v.fidx = fi; v.ftype = ft; v.fbit = fb;
    v.fagg = fg; v.ev = ev; v.eo = eo; v.er = er; v.ew = ew; v.erd = erd;
    return v;
  endfunction

  function automatic logic [5:0] pick_bit();
    case ($urandom_range(0, 3))
      0: return 6'd0;
      1: return 6'd1;
      2: return 6'd4;
      default: return 6'd63;
    endcase
  endfunction

  function automatic logic [15:0] pick_addr();
    int r;
    r = $urandom_range(0, 15);
    if (r < 11) return 16'($urandom_range(0, 7));
    if (r < 14) return 16'($urandom_range(250, 259));
    if (r == 14) return 16'd300;
    return 16'hFFFF;
  endfunction

  initial begin
    vec_t vt[$];

    // Directed vectors, checked record by record.
    vt.push_back(mk(K_WR,   3,   c_A5,   0, 0, 0,  0,  0, 0, 0,            1, 0));
    vt.push_back(mk(K_RD,   3,   0,      0, 0, 0,  0,  1, 0, c_A5,         1, 1));
    vt.push_back(mk(K_FSET, 5,   0,      0, 2, 0,  0,  0, 0, 0,            1, 1));
    vt.push_back(mk(K_WR,   5,   0,      0, 0, 0,  0,  0, 0, 0,            2, 1));
    vt.push_back(mk(K_RD,   5,   0,      0, 0, 0,  0,  1, 0, 64'h1,        2, 2));
    vt.push_back(mk(K_FCLR, 0,   0,      0, 0, 0,  0,  0, 0, 0,            2, 2));
    vt.push_back(mk(K_RD,   5,   0,      0, 0, 0,  0,  1, 0, 64'h1,        2, 3));
    vt.push_back(mk(K_FSET, 7,   0,      1, 3, 63, 0,  0, 0, 0,            2, 3));
    vt.push_back(mk(K_WR,   7,   0,      0, 0, 0,  0,  0, 0, 0,            3, 3));
    vt.push_back(mk(K_WR,   7,   c_ONES, 0, 0, 0,  0,  0, 0, 0,            4, 3));
    vt.push_back(mk(K_RD,   7,   0,      0, 0, 0,  0,  1, 0, 64'h7FFF_FFFF_FFFF_FFFF, 4, 4));
    vt.push_back(mk(K_FCLR, 0,   0,      0, 0, 0,  0,  0, 0, 0,            4, 4));
    vt.push_back(mk(K_FSET, 8,   0,      2, 4, 0,  0,  0, 0, 0,            4, 4));
    vt.push_back(mk(K_WR,   8,   c_ONES, 0, 0, 0,  0,  0, 0, 0,            5, 4));
    vt.push_back(mk(K_WR,   8,   0,      0, 0, 0,  0,  0, 0, 0,            6, 4));
    vt.push_back(mk(K_RD,   8,   0,      0, 0, 0,  0,  1, 0, 64'h1,        6, 5));
    vt.push_back(mk(K_FCLR, 0,   0,      0, 0, 0,  0,  0, 0, 0,            6, 5));
    vt.push_back(mk(K_FSET, 20,  0,      3, 5, 4,  10, 0, 0, 0,            6, 5));
    vt.push_back(mk(K_WR,   10,  0,      0, 0, 0,  0,  0, 0, 0,            7, 5));
    vt.push_back(mk(K_WR,   20,  0,      0, 0, 0,  0,  0, 0, 0,            8, 5));
    vt.push_back(mk(K_WR,   10,  64'h10, 0, 0, 0,  0,  0, 0, 0,            9, 5));
    vt.push_back(mk(K_RD,   20,  0,      0, 0, 0,  0,  1, 0, 64'h10,       9, 6));
    vt.push_back(mk(K_WR,   10,  64'h10, 0, 0, 0,  0,  0, 0, 0,            10, 6));
    vt.push_back(mk(K_RD,   20,  0,      0, 0, 0,  0,  1, 0, 64'h10,       10, 7));
    vt.push_back(mk(K_WR,   300, 64'hDEAD, 0, 0, 0, 0, 0, 1, 0,            10, 7));
    vt.push_back(mk(K_RD,   300, 0,      0, 0, 0,  0,  1, 1, 0,            10, 7));
    vt.push_back(mk(K_IDLE, 0,   0,      0, 0, 0,  0,  0, 0, 0,            10, 7));
    vt.push_back(mk(K_WR,   255, 64'h1234, 0, 0, 0, 0, 0, 0, 0,            11, 7));
    vt.push_back(mk(K_RD,   255, 0,      0, 0, 0,  0,  1, 0, 64'h1234,     11, 8));
    vt.push_back(mk(K_RD,   256, 0,      0, 0, 0,  0,  1, 1, 0,            11, 8));

    repeat (3) @(posedge clk);
    #1;
    chk("reset_rdata", rdata, 64'd0);
    chk("reset_valid", 64'(rdata_valid), 64'd0);
    chk("reset_oor", 64'(addr_oor), 64'd0);
    chk("reset_wr_count", 64'(wr_count), 64'd0);
    chk("reset_rd_count", 64'(rd_count), 64'd0);
    rst_n = 1'b1;

    for (int n = 0; n < vt.size(); n++) begin
      case (vt[n].kind)
        K_WR:    drive(1, 1, vt[n].addr, vt[n].data, 0, 0, 0, 0, 0, 0, 0);
        K_RD:    drive(1, 0, vt[n].addr, 0, 0, 0, 0, 0, 0, 0, 0);
        K_FSET:  drive(0, 0, 0, 0, 1, vt[n].fidx, vt[n].ftype, vt[n].addr, vt[n].fbit, vt[n].fagg, 0);
        K_FCLR:  drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        default: drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      endcase
      chk($sformatf("vec%0d_valid", n), 64'(rdata_valid), 64'(vt[n].ev));
      chk($sformatf("vec%0d_oor", n), 64'(addr_oor), 64'(vt[n].eo));
      if (vt[n].ev) chk($sformatf("vec%0d_rdata", n), rdata, vt[n].er);
      chk($sformatf("vec%0d_wr_count", n), 64'(wr_count), 64'(vt[n].ew));
      chk($sformatf("vec%0d_rd_count", n), 64'(rd_count), 64'(vt[n].erd));
    end

    // A fault entry written alongside a read only affects the following access.
    drive(1, 0, 3, 0, 1, 0, 3'd1, 3, 0, 0, 0);
    chk("ft_same_cycle", rdata, c_A5);
    drive(1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("ft_next_cycle", rdata, 64'hA5A5_A5A5_A5A5_A5A4);
    drive(0, 0, 0, 0, 1, 1, 3'd2, 3, 1, 0, 1);
    drive(1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("clear_wins", rdata, c_A5);

    // Reset during a read aborts it and empties the fault table.
    drive(0, 0, 0, 0, 1, 2, 3'd2, 3, 1, 0, 0);
    drive(1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("sa1_before_reset", rdata, 64'hA5A5_A5A5_A5A5_A5A7);
    rst_n = 1'b0;
    drive(1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_abort_rdata", rdata, 64'd0);
    chk("rst_abort_valid", 64'(rdata_valid), 64'd0);
    chk("rst_abort_rd_count", 64'(rd_count), 64'd0);
    chk("rst_abort_wr_count", 64'(wr_count), 64'd0);
    rst_n = 1'b1;
    drive(1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("post_reset_table_empty", rdata, c_A5);
    chk("post_reset_valid", 64'(rdata_valid), 64'd1);
    chk("post_reset_rd_count", 64'(rd_count), 64'd1);

    // Model-based random phase.
    m_wr = 0; m_rd = 1; m_rdata = c_A5;
    for (int i = 0; i < 4; i++) begin
      m_ft[i] = 0; m_fa[i] = '0; m_fg[i] = '0; m_fb[i] = 0;
    end
    for (int w = 0; w < 256; w++)
      run_cycle(1, 1, 16'(w), {$urandom, $urandom}, 0, 0, 0, 0, 0, 0, 0);

    for (int n = 0; n < 3000; n++) begin
      logic [63:0] d;
      logic [15:0] fa, fg;
      bit fwe, fclr;
      d = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 0) d = ($urandom_range(0, 1) == 0) ? 64'd0 : c_ONES;
      fwe  = ($urandom_range(0, 7) == 0);
      fclr = ($urandom_range(0, 40) == 0);
      fa   = ($urandom_range(0, 9) == 0) ? 16'd300 : 16'($urandom_range(0, 7));
      fg   = ($urandom_range(0, 9) == 0) ? 16'd300 : 16'($urandom_range(0, 7));
      run_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, pick_addr(), d,
                fwe, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), fa, pick_bit(), fg, fclr);
    end

    // Drive writes until the write counter has sat at its ceiling for a few cycles.
    while (m_wr < 65535) run_cycle(1, 1, 16'd0, 64'd0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) run_cycle(1, 1, 16'd1, 64'd5, 0, 0, 0, 0, 0, 0, 0);
    chk("wr_count_saturated", 64'(wr_count), 64'hFFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mbist_mem_responder.md
Name: mbist_mem_responder

Overview:
- Memory-side responder to the MBIST write/read/address/data interface, i.e. the block the mux/demux drives for one selected memory.
- A single-port register-array memory with a run-time programmable fault table: stuck-at, transition and coupling faults.
- Gives the MBIST controller and decoder a deterministic target for verifying March C, March A and APNPSF detection and error-threshold behaviour.

Parameters:
- DATA_WIDTH, 64, word width; must match the MBIST data width.
- ADDR_WIDTH, 16, address port width.
- DEPTH, 256, number of implemented words; DEPTH <= 2^ADDR_WIDTH.
- NUM_FAULTS, 4, fault table entries.
- FIDX_W, 2, fault index width, log2(NUM_FAULTS).
- BIT_W, 6, bit-select width, log2(DATA_WIDTH).

Ports:
- clk  in  1  clock; all logic on its rising edge.
- rst_n  in  1  synchronous active-low reset.
- mem_en  in  1  access strobe; one access per cycle while high.
- write_read  in  1  1 = write, 0 = read; sampled only when mem_en = 1.
- address  in  ADDR_WIDTH  word address.
- wdata  in  DATA_WIDTH  write data.
- rdata  out  DATA_WIDTH  read data.
- rdata_valid  out  1  one-cycle pulse marking rdata valid.
- addr_oor  out  1  one-cycle pulse: previous access had address >= DEPTH.
- fault_wr_en  in  1  write one fault table entry.
- fault_idx  in  FIDX_W  entry index.
- fault_type  in  3  0 none, 1 SA0, 2 SA1, 3 TF_UP, 4 TF_DN, 5 CF_INV; 6-7 treated as none.
- fault_addr  in  ADDR_WIDTH  victim word address.
- fault_bit  in  BIT_W  victim/aggressor bit index.
- fault_agg_addr  in  ADDR_WIDTH  aggressor address; CF_INV only.
- fault_clear  in  1  invalidate all entries.
- wr_count  out  16  saturating count of in-range writes.
- rd_count  out  16  saturating count of in-range reads.

Behaviour:
- Reset (rst_n = 0 at a clock edge):
  - rdata = 0, rdata_valid = 0, addr_oor = 0, wr_count = 0, rd_count = 0.
  - All fault entries set to type none.
  - Array contents are not reset; the bench initialises them by writes.
  - Reset asserted mid-access aborts that access: no array update, no rdata_valid.
- Read (mem_en = 1, write_read = 0, address < DEPTH):
  - Latency 1: next cycle rdata = faulted view of the word and rdata_valid = 1.
  - Faulted view = stored word with every active SA0 bit forced to 0 and every SA1 bit forced to 1.
  - rd_count increments.
  - rdata holds its value when no read is in progress.
- Write (mem_en = 1, write_read = 1, address < DEPTH):
  - Word is updated at the same edge; wr_count increments.
  - new = wdata, then for each fault entry whose fault_addr matches this address:
    - TF_UP: if old bit = 0 and wdata bit = 1, stored bit stays 0.
    - TF_DN: if old bit = 1 and wdata bit = 0, stored bit stays 1.
    - SA0/SA1: stored bit forced to 0/1. Stuck-at faults are applied after transition faults and win.
  - CF_INV: if address = fault_agg_addr and the aggressor's fault_bit changes value (old != new stored), the victim word at fault_addr has bit fault_bit inverted at the same edge.
  - An entry with fault_agg_addr = fault_addr, or either address >= DEPTH, is ignored.
- Out of range (address >= DEPTH):
  - No array change and no count change.
  - Next cycle addr_oor = 1.
  - For a read: rdata = 0 and rdata_valid = 1.
- Fault ordering:
  - Multiple entries on the same bit are applied in ascending index order; the higher index wins among stuck-at faults.
- Fault table updates:
  - fault_wr_en and fault_clear take effect for accesses starting the next cycle.
  - fault_clear and fault_wr_en in the same cycle: clear wins.
  - Fault table writes do not alter array contents.
- Counters saturate at 0xFFFF.
- mem_en = 0: no state change except fault table updates; rdata_valid = 0, addr_oor = 0.

Test Plan:
- Reset, then write 0xA5A5_A5A5_A5A5_A5A5 to addr 3 and read addr 3 -> the cycle after the read, rdata = 0xA5A5_A5A5_A5A5_A5A5 with rdata_valid = 1; wr_count = 1, rd_count = 1.
- SA1 at addr 5 bit 0, write 0 to addr 5, read addr 5 -> rdata = 0x1; then fault_clear and read addr 5 -> rdata = 0x1 (stored value remains forced).
- TF_UP at addr 7 bit 63:
  - write 0, then write 0xFFFF_FFFF_FFFF_FFFF, read addr 7 -> rdata = 0x7FFF_FFFF_FFFF_FFFF.
  - TF_DN variant at bit 0: write all-ones, then 0, read -> rdata = 0x1.
- CF_INV aggressor addr 10, victim addr 20, bit 4:
  - write 0 to both, then 0x10 to addr 10 -> addr 20 reads 0x10.
  - rewrite 0x10 to addr 10 (no transition) -> addr 20 still reads 0x10.
- Address 300 with DEPTH = 256:
  - write -> addr_oor pulse, wr_count unchanged.
  - read -> rdata = 0, rdata_valid = 1, addr_oor = 1.
- Read issued, with rst_n low on the next edge -> rdata = 0 and rdata_valid = 0 after reset; fault table is empty.
